// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration of shift-add multiply or restoring divide
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     opnd,
    input  logic [2*WIDTH-1:0]   acc_in,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;

    // Multiply: acc = {partial product, remaining multiplier bits}; add on lsb then shift right.
    // Divide: acc = {remainder, dividend/quotient}; shift left one bit and trial-subtract the divisor.
    always_comb begin
        sum      = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
        shifted  = acc_in[2*WIDTH-1:WIDTH-1];
        diff     = shifted - {1'b0, opnd};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        if (is_div) begin
            acc_out = {rem_next, acc_in[WIDTH-2:0], q_bit};
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   step_acc;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_q[1]),
        .opnd    (opnd_q),
        .acc_in  (acc_q),
        .acc_out (step_acc)
    );

    // Next-state logic: operand capture in IDLE, one step per RUN cycle, sign fix and HI/LO write in FIN.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        signed_op = ~op[0];
        a_mag     = (signed_op && A[WIDTH-1]) ? -A : A;
        b_mag     = (signed_op && B[WIDTH-1]) ? -B : B;
        prod      = neg_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                // MTHI/MTLO only land while idle; a same-cycle start result overwrites them at FIN.
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d   = RUN;
                    op_d      = op;
                    cnt_d     = '0;
                    neg_d     = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rem_neg_d = signed_op & A[WIDTH-1];
                    if (op[1]) begin
                        opnd_d = b_mag;
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                    end
                end
            end
            RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITERATIONS - 1)) state_d = FIN;
            end
            FIN: begin
                if (op_q[1]) begin
                    hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    int          done_k;
    int          done_n;
    int          busy_n;
    logic [31:0] hi_mid;
    logic [31:0] hi_before;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch 45 cycles; optionally poke start/hi_we while busy at cycle inj_k.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_k, output int dk, output int dn, output int bn,
                          output logic [31:0] hm);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1 start = 1'b0;
        dk = -1; dn = 0; bn = 0; hm = hi;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (k == inj_k + 1) hm = hi;
            start = 1'b0;
            hi_we = 1'b0;
            if (busy) bn++;
            if (done) begin
                dn++;
                if (dk < 0) dk = k;
            end
            if (k == inj_k) begin
                start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7;
                hi_we = 1'b1; wdata = 32'h1234;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, done_k, done_n, busy_n, hi_mid);
        chk("multu_max_hi", {32'd0, hi}, 64'hFFFFFFFE);
        chk("multu_max_lo", {32'd0, lo}, 64'h00000001);
        chk("multu_done_latency", 64'(done_k), 64'd33);
        chk("multu_busy_cycles", 64'(busy_n), 64'd33);
        chk("multu_done_count", 64'(done_n), 64'd1);

        run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, -1, done_k, done_n, busy_n, hi_mid);
        chk("mult_neg_hi", {32'd0, hi}, 64'hFFFFFFFF);
        chk("mult_neg_lo", {32'd0, lo}, 64'hFFFFFFF1);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, done_k, done_n, busy_n, hi_mid);
        chk("div_neg_lo", {32'd0, lo}, 64'hFFFFFFFD);
        chk("div_neg_hi", {32'd0, hi}, 64'hFFFFFFFF);

        run_op(OP_DIVU, 32'd7, 32'd0, -1, done_k, done_n, busy_n, hi_mid);
        chk("divu_zero_lo", {32'd0, lo}, 64'hFFFFFFFF);
        chk("divu_zero_hi", {32'd0, hi}, 64'h00000007);

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, done_k, done_n, busy_n, hi_mid);
        chk("div_ovf_lo", {32'd0, lo}, 64'h80000000);
        chk("div_ovf_hi", {32'd0, hi}, 64'h00000000);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, -1, done_k, done_n, busy_n, hi_mid);
        chk("div_negzero_lo", {32'd0, lo}, 64'h00000001);
        chk("div_negzero_hi", {32'd0, hi}, 64'hFFFFFFF9);

        hi_before = hi;
        run_op(OP_MULTU, 32'h00010000, 32'h00030000, 5, done_k, done_n, busy_n, hi_mid);
        chk("busy_hi_we_dropped", {32'd0, hi_mid}, {32'd0, hi_before});
        chk("busy_start_hi", {32'd0, hi}, 64'h00000003);
        chk("busy_start_lo", {32'd0, lo}, 64'h00000000);
        chk("busy_start_done_count", 64'(done_n), 64'd1);

        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk);
        #1 lo_we = 1'b0;
        @(negedge clk);
        chk("idle_lo_we", {32'd0, lo}, 64'h0000ABCD);
        chk("idle_lo_we_hi_kept", {32'd0, hi}, 64'h00000003);

        @(negedge clk);
        start = 1'b1; op = OP_MULTU; A = 32'd5; B = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_busy", {63'd0, busy}, 64'd0);
        chk("midrun_rst_done", {63'd0, done}, 64'd0);
        chk("midrun_rst_hi", {32'd0, hi}, 64'd0);
        chk("midrun_rst_lo", {32'd0, lo}, 64'd0);
        done_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        chk("midrun_rst_no_done", 64'(done_n), 64'd0);

        run_op(OP_MULTU, 32'd3, 32'd4, -1, done_k, done_n, busy_n, hi_mid);
        chk("after_rst_lo", {32'd0, lo}, 64'd12);
        chk("after_rst_hi", {32'd0, hi}, 64'd0);
        chk("after_rst_done_latency", 64'(done_k), 64'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers. It sits beside the barrel shifter in the EX stage and consumes the same 32-bit operand buses: A is the multiplicand or dividend, B is the multiplier or divisor. It executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles and also serves MTHI/MTLO writes. It exposes `busy` so the pipeline can stall MFHI/MFLO and back-to-back mul/div issue.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; only 32 is verified.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`  in  32  multiplicand or dividend.
- `B`  in  32  multiplier or divisor.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIN.
- **IDLE → RUN** on `start`=1. Latch `op`, and latch A and B as magnitudes when the op is signed (MULT/DIV). Latch the result-sign flags. Clear the 5-bit iteration counter.
- **RUN**: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract into a 32-bit remainder and a 32-bit quotient.
  - After the step with counter = 31, go to FIN.
- **FIN**:
  - Apply the sign fix.
    - Signed multiply: negate the 64-bit product if sign(A) ≠ sign(B).
    - Signed divide: negate the quotient if sign(A) ≠ sign(B); negate the remainder if sign(A) = 1.
  - Write HI/LO. Multiply: HI = product[63:32], LO = product[31:0]. Divide: HI = remainder, LO = quotient.
  - Pulse `done` and return to IDLE.
- Divide by zero falls out of the restoring algorithm with no exception.
  - DIVU: LO = 0xFFFFFFFF, HI = A.
  - DIV: sign fix applies to the magnitude result, so A ≥ 0 gives LO = 0xFFFFFFFF and A < 0 gives LO = 0x00000001; HI = A in both cases.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps, no trap).
- `start` while `busy`=1 is ignored; there is no queueing.
- `hi_we`/`lo_we` while `busy`=1 are dropped. In IDLE they update the register at the next edge.
- `start` and a write in the same IDLE cycle: both are taken. The write lands now; the result overwrites it at FIN.
- `rst` at any point, including mid-RUN: state = IDLE, `busy` = 0, `done` = 0, `hi` = `lo` = 0. The in-flight operation is discarded.

## Timing
- `start` is sampled at edge E0.
- `busy` = 1 from after E0 through E33.
- RUN covers edges E1..E32.
- FIN is the cycle after E32; HI/LO update at E33.
- `done` = 1 for the single cycle after E33, with `busy` = 0 in that cycle.
- New results are visible on `hi`/`lo` 33 cycles after the start edge.
- A new `start` is accepted in the `done` cycle.
- Reset values: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.
- `hi` and `lo` are direct register outputs with no combinational path from the inputs.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - state enum `{IDLE, RUN, FIN}`;
  - constant `ITERATIONS = 32`.
- One sub-module, `muldiv_step`: purely combinational single iteration covering both the multiply and the divide step. The top level holds the FSM, counter, sign flags and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001, `done` exactly 33 cycles after the start edge, `busy` high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 7; DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- `start` pulsed at cycle 5 of a running MULTU with different operands → ignored; the first result is unchanged and only one `done` is seen.
- `hi_we` with wdata = 0x1234 while busy → HI unaffected. `lo_we` with 0xABCD in IDLE → LO = 0xABCD next cycle.
- `rst` asserted at RUN cycle 10 → next cycle `busy` = 0, `hi` = `lo` = 0, no `done`. A subsequent MULTU 3 × 4 gives LO = 12.
